// File: rtl/dvp_pkg.sv
// Shared encodings for the DVP raw Bayer pattern source: pattern selects,
// timing FSM states, colour-bar table and Bayer site decode.
package dvp_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP   = 2'd0,
        PAT_BARS   = 2'd1,
        PAT_CONST  = 2'd2,
        PAT_MOVING = 2'd3
    } pat_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } dvp_state_e;

    typedef enum logic [1:0] {
        SITE_R  = 2'b00,
        SITE_GR = 2'b01,
        SITE_GB = 2'b10,
        SITE_B  = 2'b11
    } bayer_site_e;

    // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic bayer_site_e site_of(input logic y0, input logic x0);
        return bayer_site_e'({y0, x0});
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational pixel generator; the top registers its output into Data.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        href,
    input  logic [11:0] x,
    input  logic [7:0]  y,
    input  logic [1:0]  pat_sel,
    input  logic [7:0]  const_val,
    input  logic [7:0]  frame_cnt,
    output logic [7:0]  data
);

    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] bar_full;
    logic [2:0]  rgb;

    assign bar_full = x / BAR_W;

    always_comb begin
        data = '0;
        rgb  = BAR_RGB[bar_full[2:0]];
        if (href) begin
            case (pat_sel)
                PAT_RAMP:  data = x[7:0];
                PAT_BARS: begin
                    case (site_of(y[0], x[0]))
                        SITE_R:  data = {8{rgb[2]}};
                        SITE_B:  data = {8{rgb[0]}};
                        default: data = {8{rgb[1]}};
                    endcase
                end
                PAT_CONST: data = const_val;
                default:   data = x[7:0] + y + frame_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dvp_raw_pattern_tx.sv
// DVP raw Bayer sensor emulator: frame timing FSM, counters and registered outputs.
//   state     | meaning
//   ST_IDLE   | outputs low, waiting for En
//   ST_VSYNC  | Vsync high for VSYNC_LINES line periods
//   ST_VBP    | vertical back porch
//   ST_ACTIVE | V_ACTIVE lines, Href high for the first H_ACTIVE cycles of each
//   ST_VFP    | vertical front porch; last cycle pulses FrameDone
module dvp_raw_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP_LINES  = 17,
    parameter int V_FP_LINES  = 10
) (
    input  logic       PCLK,
    input  logic       Rst_n,
    input  logic       En,
    input  logic [1:0] PatSel,
    input  logic [7:0] ConstVal,
    output logic       Vsync,
    output logic       Href,
    output logic [7:0] Data,
    output logic       FrameStart,
    output logic       FrameDone,
    output logic [7:0] FrameCnt
);

    localparam int          LINE_LEN = H_ACTIVE + H_BLANK;
    localparam logic [11:0] H_LAST   = 12'(LINE_LEN - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);

    if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0) $error("H_ACTIVE must be >= 8 and a multiple of 8");
    if (H_BLANK < 1) $error("H_BLANK must be >= 1");
    if (LINE_LEN > 4096) $error("line length exceeds 12-bit hcnt");
    if (V_ACTIVE < 1 || V_ACTIVE > 2048) $error("V_ACTIVE out of range");
    if (VSYNC_LINES < 1 || VSYNC_LINES > 2048) $error("VSYNC_LINES out of range");
    if (V_BP_LINES < 1 || V_BP_LINES > 2048) $error("V_BP_LINES out of range");
    if (V_FP_LINES < 1 || V_FP_LINES > 2048) $error("V_FP_LINES out of range");

    dvp_state_e  state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] lcnt_q, lcnt_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  const_q, const_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        fs_q, fs_d;
    logic        done_q, done_d;
    logic        line_end, last_line, start;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        lcnt_d    = lcnt_q;
        start     = 1'b0;
        line_end  = (hcnt_q == H_LAST);
        last_line = 1'b0;

        case (state_q)
            ST_VSYNC:  last_line = (lcnt_q == 11'(VSYNC_LINES - 1));
            ST_VBP:    last_line = (lcnt_q == 11'(V_BP_LINES - 1));
            ST_ACTIVE: last_line = (lcnt_q == 11'(V_ACTIVE - 1));
            ST_VFP:    last_line = (lcnt_q == 11'(V_FP_LINES - 1));
            default:   last_line = 1'b0;
        endcase

        if (state_q == ST_IDLE) begin
            hcnt_d = '0;
            lcnt_d = '0;
            start  = En;
        end else begin
            hcnt_d = line_end ? 12'd0 : hcnt_q + 12'd1;
            if (line_end) begin
                lcnt_d = last_line ? 11'd0 : lcnt_q + 11'd1;
                if (last_line) begin
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBP;
                        ST_VBP:    state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFP;
                        ST_VFP: begin
                            state_d = ST_IDLE;
                            start   = En;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
        end

        // A new frame always begins with hcnt/lcnt cleared, whether from IDLE or back-to-back.
        if (start) begin
            state_d = ST_VSYNC;
            hcnt_d  = '0;
            lcnt_d  = '0;
        end

        // Outputs are registered from the next-state view so they line up with state_q.
        vsync_d     = (state_d == ST_VSYNC);
        href_d      = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT);
        fs_d        = start;
        done_d      = (state_d == ST_VFP) && (hcnt_d == H_LAST)
                      && (lcnt_d == 11'(V_FP_LINES - 1));
        frame_cnt_d = frame_cnt_q + {7'd0, done_d};
        pat_d       = start ? PatSel : pat_q;
        const_d     = start ? ConstVal : const_q;
    end

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .href      (href_d),
        .x         (hcnt_d),
        .y         (lcnt_d[7:0]),
        .pat_sel   (pat_q),
        .const_val (const_q),
        .frame_cnt (frame_cnt_q),
        .data      (data_d)
    );

    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            pat_q       <= '0;
            const_q     <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            fs_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            pat_q       <= pat_d;
            const_q     <= const_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            fs_q        <= fs_d;
            done_q      <= done_d;
        end
    end

    assign Vsync      = vsync_q;
    assign Href       = href_q;
    assign Data       = data_q;
    assign FrameStart = fs_q;
    assign FrameDone  = done_q;
    assign FrameCnt   = frame_cnt_q;

endmodule

// File: tb/tb_dvp_raw_pattern_tx.sv
// Scoreboard bench for dvp_raw_pattern_tx with a reduced frame (12-cycle lines, 84-cycle frames).
module tb_dvp_raw_pattern_tx;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_ACTIVE = 4;
    localparam int FRAME    = 84;

    logic       PCLK = 1'b0;
    logic       Rst_n;
    logic       En;
    logic [1:0] PatSel;
    logic [7:0] ConstVal;
    logic       Vsync, Href, FrameStart, FrameDone;
    logic [7:0] Data, FrameCnt;

    dvp_raw_pattern_tx #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (1),
        .V_BP_LINES  (1),
        .V_FP_LINES  (1)
    ) dut (
        .PCLK       (PCLK),
        .Rst_n      (Rst_n),
        .En         (En),
        .PatSel     (PatSel),
        .ConstVal   (ConstVal),
        .Vsync      (Vsync),
        .Href       (Href),
        .Data       (Data),
        .FrameStart (FrameStart),
        .FrameDone  (FrameDone),
        .FrameCnt   (FrameCnt)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_fc = 0;
    int prev_t = 0;
    logic [7:0] exp_data_q[$];
    logic [7:0] exp_cnt_q[$];

    // Bayer samples of the eight bars, hand-derived: even lines R/G sites, odd lines G/B sites
    logic [7:0] bars_even [8] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] bars_odd  [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int pat, input logic [7:0] cv,
                                           input int x, input int y, input int fc);
        case (pat)
            0:       return 8'(x);
            1:       return (y % 2 == 0) ? bars_even[x] : bars_odd[x];
            2:       return cv;
            default: return 8'((x + y + fc) % 256);
        endcase
    endfunction

    // Waits for FrameStart, checks frame period when back-to-back, queues expectations.
    task automatic frame_begin(input int pat, input logic [7:0] cv, input bit b2b);
        int n = 0;
        while (FrameStart !== 1'b1 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (FrameStart !== 1'b1) begin
            chk("frame_start_timeout", 0, 1);
            return;
        end
        if (b2b) chk("frame_period", cyc - prev_t, FRAME);
        prev_t = cyc;
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++)
                exp_data_q.push_back(exp_pix(pat, cv, x, y, exp_fc));
        exp_fc = (exp_fc + 1) % 256;
        exp_cnt_q.push_back(8'(exp_fc));
        @(negedge PCLK);
    endtask

    task automatic wait_done();
        int n = 0;
        while (FrameDone !== 1'b1 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (FrameDone !== 1'b1) chk("frame_done_timeout", 0, 1);
    endtask

    // Monitor
    int t_fs = -1000;
    int href_n = 0;
    bit seen_href = 0;
    logic vsync_prev = 1'b0;

    always @(negedge PCLK) begin
        if (Rst_n === 1'b1) begin
            if (FrameStart) begin
                t_fs = cyc;
                href_n = 0;
                seen_href = 0;
                chk("vsync_at_start", int'(Vsync), 1);
            end
            if (Href) begin
                if (!seen_href) begin
                    chk("first_href_delay", cyc - t_fs, 24);
                    seen_href = 1;
                end
                href_n++;
                if (exp_data_q.size() == 0) chk("data_unexpected", int'(Data), -1);
                else chk("data", int'(Data), int'(exp_data_q.pop_front()));
            end else if (Data !== 8'h00) begin
                chk("data_blank", int'(Data), 0);
            end
            if (vsync_prev && !Vsync) chk("vsync_len", cyc - t_fs, 12);
            if (FrameDone) begin
                chk("done_pos", cyc - t_fs, FRAME - 1);
                chk("href_count", href_n, 32);
                if (exp_cnt_q.size() == 0) chk("framecnt_unexpected", int'(FrameCnt), -1);
                else chk("framecnt", int'(FrameCnt), int'(exp_cnt_q.pop_front()));
            end
            vsync_prev = Vsync;
        end else begin
            vsync_prev = 1'b0;
        end
    end

    initial begin
        Rst_n = 1'b0; En = 1'b0; PatSel = 2'd0; ConstVal = 8'h00;
        repeat (3) @(negedge PCLK);
        chk("rst_vsync", int'(Vsync), 0);
        chk("rst_href", int'(Href), 0);
        chk("rst_data", int'(Data), 0);
        chk("rst_fs", int'(FrameStart), 0);
        chk("rst_fd", int'(FrameDone), 0);
        chk("rst_framecnt", int'(FrameCnt), 0);

        Rst_n = 1'b1;
        En = 1'b1;
        PatSel = 2'd0;
        @(negedge PCLK);

        // Frame A: ramp; mid-frame select bars for the next frame
        frame_begin(0, 8'h00, 1'b0);
        repeat (30) @(negedge PCLK);
        PatSel = 2'd1; ConstVal = 8'h5A;

        // Frame B: bars; mid-frame select constant
        frame_begin(1, 8'h5A, 1'b1);
        repeat (30) @(negedge PCLK);
        PatSel = 2'd2; ConstVal = 8'h5A;

        // Frame C: constant; mid-frame tear attempt and En drop
        frame_begin(2, 8'h5A, 1'b1);
        repeat (30) @(negedge PCLK);
        PatSel = 2'd0; ConstVal = 8'hC3; En = 1'b0;
        wait_done();
        repeat (5) @(negedge PCLK);
        chk("idle_vsync", int'(Vsync), 0);
        chk("idle_href", int'(Href), 0);
        chk("idle_data", int'(Data), 0);
        begin
            int starts = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge PCLK);
                if (FrameStart || Vsync) starts++;
            end
            chk("idle_no_restart", starts, 0);
        end

        // Frame D: restart from idle, then reset in the middle of an active line
        En = 1'b1; PatSel = 2'd0;
        frame_begin(0, 8'h00, 1'b0);
        begin
            int n = 0;
            while (Href !== 1'b1 && n < 100) begin
                @(negedge PCLK);
                n++;
            end
            chk("href_before_reset", int'(Href), 1);
        end
        repeat (2) @(negedge PCLK);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_vsync", int'(Vsync), 0);
        chk("midrst_href", int'(Href), 0);
        chk("midrst_data", int'(Data), 0);
        chk("midrst_framecnt", int'(FrameCnt), 0);
        exp_data_q.delete();
        exp_cnt_q.delete();
        exp_fc = 0;
        repeat (2) @(negedge PCLK);

        // 256 back-to-back moving-ramp frames; FrameCnt wraps to 0 on the last
        PatSel = 2'd3; En = 1'b1;
        Rst_n = 1'b1;
        for (int f = 0; f < 256; f++) begin
            frame_begin(3, 8'h00, f > 0);
            if (f == 255) begin
                repeat (30) @(negedge PCLK);
                En = 1'b0;
            end
        end
        wait_done();
        repeat (3) @(negedge PCLK);
        chk("wrap_framecnt", int'(FrameCnt), 0);
        chk("data_queue_drained", exp_data_q.size(), 0);
        chk("cnt_queue_drained", exp_cnt_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
